gate_sequencer: RTL and testbench

//  Measurement sequencer for the frequency meter counting datapath. Runs the

---
 rtl/gate_sequencer_if.sv | 25 ++
 rtl/gate_sequencer.sv | 138 +++++++++++++
 tb/tb_gate_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if: front-panel and datapath signals of the frequency-meter gate sequencer.
`default_nettype none

interface gate_sequencer_if;
  logic       start;
  logic [1:0] range;
  logic       ovf;
  logic       cnt_clr;
  logic       en;
  logic       latch;
  logic       busy;
  logic       err;

  modport master (
    output start, range, ovf,
    input  cnt_clr, en, latch, busy, err
  );

  modport slave (
    input  start, range, ovf,
    output cnt_clr, en, latch, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/gate_sequencer.sv
// gate_sequencer: CLEAR -> GATE -> LATCH -> HOLD measurement sequencer for the frequency meter.
// All outputs are registers updated on state transitions, so none depends combinationally on inputs.
`default_nettype none

module gate_sequencer #(
  parameter int GATE_LEN = 50_000_000,
  parameter int CLR_LEN  = 2,
  parameter int HOLD_LEN = 25_000_000,
  parameter int TMR_W    = 26
) (
  input  logic             clk_i,
  input  logic             clr_i,
  gate_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_GATE  = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Reload values are "length - 1": the timer counts down to zero inclusive.
  localparam logic [TMR_W-1:0] C_CLR_LD   = TMR_W'(CLR_LEN - 1);
  localparam logic [TMR_W-1:0] C_HOLD_LD  = TMR_W'(HOLD_LEN - 1);
  localparam logic [TMR_W-1:0] C_GATE_LD0 = TMR_W'(GATE_LEN - 1);
  localparam logic [TMR_W-1:0] C_GATE_LD1 = TMR_W'(GATE_LEN / 10 - 1);
  localparam logic [TMR_W-1:0] C_GATE_LD2 = TMR_W'(GATE_LEN / 100 - 1);

  state_t             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [1:0]         range_q;
  logic               cnt_clr_q;
  logic               en_q;
  logic               latch_q;
  logic               busy_q;
  logic               err_q;
  logic [TMR_W-1:0]   gate_ld;

  always_comb begin
    gate_ld = C_GATE_LD0;
    unique case (range_q)
      2'd0:    gate_ld = C_GATE_LD0;
      2'd1:    gate_ld = C_GATE_LD1;
      default: gate_ld = C_GATE_LD2;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      range_q   <= 2'd0;
      cnt_clr_q <= 1'b0;
      en_q      <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_CLEAR;
            timer_q   <= C_CLR_LD;
            range_q   <= bus.range;
            cnt_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (timer_q == '0) begin
            state_q   <= S_GATE;
            timer_q   <= gate_ld;
            cnt_clr_q <= 1'b0;
            en_q      <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_GATE: begin
          // Overflow cuts the gate short at the same edge it is seen.
          if (bus.ovf || (timer_q == '0)) begin
            state_q <= S_LATCH;
            timer_q <= '0;
            en_q    <= 1'b0;
            latch_q <= 1'b1;
            if (bus.ovf) begin
              err_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_LATCH: begin
          state_q <= S_HOLD;
          timer_q <= C_HOLD_LD;
          latch_q <= 1'b0;
        end
        S_HOLD: begin
          if (timer_q == '0) begin
            if (bus.start) begin
              state_q   <= S_CLEAR;
              timer_q   <= C_CLR_LD;
              range_q   <= bus.range;
              cnt_clr_q <= 1'b1;
              err_q     <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              timer_q <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          timer_q   <= '0;
          cnt_clr_q <= 1'b0;
          en_q      <= 1'b0;
          latch_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_clr = cnt_clr_q;
  assign bus.en      = en_q;
  assign bus.latch   = latch_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: directed vector table plus hand sequences for gate_sequencer (GATE_LEN=200).
`default_nettype none

module tb_gate_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  gate_sequencer_if bus ();

  gate_sequencer #(
    .GATE_LEN (200),
    .CLR_LEN  (2),
    .HOLD_LEN (3),
    .TMR_W    (8)
  ) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rng;
    int         ovf_at;   // 0 = no overflow
    int         exp_g;
    logic       exp_err;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One START pulse; profiles the resulting sequence cycle by cycle.
  task automatic run_seq(input string nm, input logic [1:0] rng, input int ovf_at,
                         input int exp_g, input logic exp_err);
    int   n_clr = 0, n_en = 0, n_lat = 0, n_busy = 0, excl = 0, lat_pos = -1, cyc = 0;
    logic err_entry;
    bit   done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.range = rng;
    @(posedge clk); #1;
    bus.start = 1'b0;
    err_entry = bus.err;
    while (!done && cyc < 1000) begin
      if (bus.busy) n_busy++; else done = 1;
      if (bus.cnt_clr) n_clr++;
      if (bus.en) n_en++;
      if (bus.latch) begin n_lat++; lat_pos = cyc; end
      if ((int'(bus.cnt_clr) + int'(bus.en) + int'(bus.latch)) > 1) excl++;
      bus.ovf = (ovf_at != 0) && bus.en && (n_en == ovf_at);
      // Changing RANGE mid-gate must not alter the current gate length.
      if (bus.en && n_en == 1) bus.range = (rng == 2'd0) ? 2'd1 : 2'd0;
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.ovf = 1'b0;
    chk({nm, " timeout"}, int'(done), 1);
    chk({nm, " err_on_clear"}, int'(err_entry), 0);
    chk({nm, " cnt_clr_cycles"}, n_clr, 2);
    chk({nm, " en_cycles"}, n_en, exp_g);
    chk({nm, " latch_cycles"}, n_lat, 1);
    chk({nm, " latch_pos"}, lat_pos, exp_g + 2);
    chk({nm, " busy_cycles"}, n_busy, exp_g + 6);
    chk({nm, " exclusive"}, excl, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " err_idle"}, int'(bus.err), int'(exp_err));
    chk({nm, " idle_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    vt[0] = '{2'd0, 0,  200, 1'b0};
    vt[1] = '{2'd1, 0,  20,  1'b0};
    vt[2] = '{2'd3, 0,  2,   1'b0};
    vt[3] = '{2'd2, 0,  2,   1'b0};
    vt[4] = '{2'd0, 50, 50,  1'b1};
    vt[5] = '{2'd1, 0,  20,  1'b0};

    // Reset with active inputs: everything low, stays idle after release.
    bus.start = 1'b1;
    bus.range = 2'd2;
    bus.ovf   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cnt_clr", int'(bus.cnt_clr), 0);
    chk("rst en",      int'(bus.en), 0);
    chk("rst latch",   int'(bus.latch), 0);
    chk("rst busy",    int'(bus.busy), 0);
    chk("rst err",     int'(bus.err), 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.ovf   = 1'b0;
    clr       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle after rst busy",    int'(bus.busy), 0);
    chk("idle after rst cnt_clr", int'(bus.cnt_clr), 0);

    for (int i = 0; i < 6; i++) begin
      run_seq($sformatf("vec%0d", i), vt[i].rng, vt[i].ovf_at, vt[i].exp_g, vt[i].exp_err);
    end

    // Continuous run with START held; RANGE change takes effect at the following CLEAR.
    begin
      int   rise[4];
      int   enc[4];
      int   nseq = 0;
      logic prev_clr = 1'b0;
      bit   fin = 0;
      for (int j = 0; j < 4; j++) begin rise[j] = 0; enc[j] = 0; end
      @(negedge clk);
      bus.start = 1'b1;
      bus.range = 2'd0;
      for (int c = 0; c < 1000 && !fin; c++) begin
        @(posedge clk); #1;
        if (bus.cnt_clr && !prev_clr && nseq < 4) begin
          rise[nseq] = c;
          nseq++;
        end
        prev_clr = bus.cnt_clr;
        if (bus.en && nseq > 0) enc[nseq-1]++;
        if (nseq == 2 && bus.en) bus.range = 2'd1;
        if (nseq >= 3) bus.start = 1'b0;
        if (nseq >= 3 && !bus.busy) fin = 1;
      end
      bus.start = 1'b0;
      chk("cont done", int'(fin), 1);
      chk("cont seqs", nseq, 3);
      chk("cont period1", rise[1] - rise[0], 206);
      chk("cont period2", rise[2] - rise[1], 206);
      chk("cont en1", enc[0], 200);
      chk("cont en2", enc[1], 200);
      chk("cont en3", enc[2], 20);
    end

    // Reset during the 100th EN cycle, then a full restart.
    begin
      int n_en = 0;
      bit hit = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.range = 2'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
        if (bus.en) n_en++;
        if (n_en == 100) hit = 1;
        else begin @(posedge clk); #1; end
      end
      chk("midclr reached", int'(hit), 1);
      clr = 1'b1;
      #1;
      chk("midclr en",   int'(bus.en), 0);
      chk("midclr busy", int'(bus.busy), 0);
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midclr idle", int'(bus.busy), 0);
      run_seq("restart", 2'd0, 0, 200, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
